// File: rtl/funrv32_decode_stage.sv
// funrv32_decode_stage: RV32I decode stage with operand capture, writeback bypass and registered valid/ready output
module funrv32_decode_stage (
    input  logic        clk,
    input  logic        resetb,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rf_a1,
    output logic [4:0]  rf_a2,
    input  logic [31:0] rf_r1,
    input  logic [31:0] rf_r2,
    input  logic        wb_we,
    input  logic [4:0]  wb_ad,
    input  logic [31:0] wb_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_rs1,
    output logic [31:0] out_rs2,
    output logic [4:0]  out_rs1_addr,
    output logic [4:0]  out_rs2_addr,
    output logic [4:0]  out_rd_addr,
    output logic [31:0] out_imm,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic        out_illegal
);
    logic [6:0]  op;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        accept;
    logic        stall;

    assign op       = in_instr[6:0];
    assign rf_a1    = in_instr[19:15];
    assign rf_a2    = in_instr[24:20];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign stall    = out_valid && !out_ready;
    assign op1      = rf_a1 == 5'd0 ? 32'd0 : (wb_we && wb_ad == rf_a1) ? wb_rd : rf_r1;
    assign op2      = rf_a2 == 5'd0 ? 32'd0 : (wb_we && wb_ad == rf_a2) ? wb_rd : rf_r2;

    // immediate format and legality from the opcode; the opcode includes instr[1:0]
    always_comb begin
        imm   = 32'd0;
        legal = 1'b1;
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                imm = {{20{in_instr[31]}}, in_instr[31:20]};
            7'b0100011:
                imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            7'b1100011:
                imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm = {in_instr[31:12], 12'd0};
            7'b1101111:
                imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            7'b0110011, 7'b0001111:
                imm = 32'd0;
            default:
                legal = 1'b0;
        endcase
    end

    // output register: reset > flush > accept > consume > stall-coherent hold
    always_ff @(posedge clk) begin
        if (!resetb) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rs1_addr <= '0;
            out_rs2_addr <= '0;
            out_rd_addr  <= '0;
            out_imm      <= '0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7b5 <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_rs1      <= op1;
            out_rs2      <= op2;
            out_rs1_addr <= rf_a1;
            out_rs2_addr <= rf_a2;
            out_rd_addr  <= in_instr[11:7];
            out_imm      <= imm;
            out_opcode   <= op;
            out_funct3   <= in_instr[14:12];
            out_funct7b5 <= in_instr[30];
            out_illegal  <= !legal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (stall) begin
            if (wb_we && wb_ad != 5'd0 && wb_ad == out_rs1_addr) out_rs1 <= wb_rd;
            if (wb_we && wb_ad != 5'd0 && wb_ad == out_rs2_addr) out_rs2 <= wb_rd;
        end
    end
endmodule
